// File: rtl/hc02_quad_nor.sv
// rtl/hc02_quad_nor.sv - WIDTH-gate 2-input NOR with registered copy and change flags
module hc02_quad_nor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [WIDTH-1:0] changed,
    output logic             any_changed
);

    // Reset value of all ones is the NOR of idle-low inputs, so the jump
    // into reset never needs its own change pulse.
    localparam logic [WIDTH-1:0] IDLE_NOR = {WIDTH{1'b1}};

    logic [WIDTH-1:0] nor_next;

    assign nor_next = ~(a | b);
    assign y        = nor_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= IDLE_NOR;
            changed <= '0;
        end else begin
            y_q     <= nor_next;
            changed <= nor_next ^ y_q;
        end
    end

    assign any_changed = |changed;

endmodule

// File: tb/tb_hc02_quad_nor.sv
// tb/tb_hc02_quad_nor.sv - scoreboard bench for hc02_quad_nor
module tb_hc02_quad_nor;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] ch;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic [W-1:0] y_q;
    logic [W-1:0] changed;
    logic         any_changed;

    int checks = 0;
    int errors = 0;

    exp_t         sb[$];
    logic [W-1:0] model_q;
    logic [W-1:0] model_ch;

    hc02_quad_nor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .y          (y),
        .y_q        (y_q),
        .changed    (changed),
        .any_changed(any_changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive on negedge, check y combinationally, push the
    // expected register state, then pop and compare after the rising edge.
    task automatic step(input logic r, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        logic [W-1:0] nor_v;
        @(negedge clk);
        rst = r;
        a   = av;
        b   = bv;
        #1;
        nor_v = 4'b1111;
        for (int i = 0; i < W; i++)
            nor_v[i] = !(av[i] || bv[i]);
        check("y", {28'd0, y}, {28'd0, nor_v});
        if (r) begin
            model_ch = '0;
            model_q  = '1;
        end else begin
            model_ch = nor_v ^ model_q;
            model_q  = nor_v;
        end
        e.q  = model_q;
        e.ch = model_ch;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("y_q", {28'd0, y_q}, {28'd0, e.q});
            check("changed", {28'd0, changed}, {28'd0, e.ch});
            check("any_changed", {31'd0, any_changed}, {31'd0, (e.ch != 0)});
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        model_q  = '1;
        model_ch = '0;

        // Reset with a=F: y already 0, registers at reset values
        step(1'b1, 4'hF, 4'h0);
        step(1'b1, 4'hF, 4'h0);
        check("rst_y_q", {28'd0, y_q}, 32'hF);
        check("rst_changed", {28'd0, changed}, 32'h0);

        // Steady idle inputs: nothing changes
        for (int i = 0; i < 10; i++)
            step(1'b0, 4'h0, 4'h0);
        check("steady_y_q", {28'd0, y_q}, 32'hF);

        // Gate-0 truth table 00,10,11,01,00
        step(1'b0, 4'h0, 4'h0);
        step(1'b0, 4'h1, 4'h0);
        check("g0_fall_pulse", {31'd0, changed[0]}, 32'd1);
        step(1'b0, 4'h1, 4'h1);
        check("g0_hold", {31'd0, changed[0]}, 32'd0);
        step(1'b0, 4'h0, 4'h1);
        step(1'b0, 4'h0, 4'h0);
        check("g0_rise_pulse", {31'd0, changed[0]}, 32'd1);

        // Independence from reset state
        step(1'b1, 4'h0, 4'h0);
        step(1'b0, 4'b0101, 4'b0011);
        check("indep_y_q", {28'd0, y_q}, 32'h8);
        check("indep_changed", {28'd0, changed}, 32'h7);

        // Mid-run reset from y_q=0, release with idle inputs
        step(1'b0, 4'hF, 4'h0);
        step(1'b0, 4'hF, 4'h0);
        check("mid_pre_y_q", {28'd0, y_q}, 32'h0);
        step(1'b1, 4'hF, 4'h0);
        check("mid_rst_changed", {28'd0, changed}, 32'h0);
        step(1'b0, 4'h0, 4'h0);
        check("mid_release_changed", {28'd0, changed}, 32'h0);

        // Swap inputs on gate 2: 01 -> 10
        step(1'b0, 4'b0000, 4'b0100);
        step(1'b0, 4'b0000, 4'b0100);
        step(1'b0, 4'b0100, 4'b0000);
        check("swap_y_q2", {31'd0, y_q[2]}, 32'd0);
        check("swap_changed2", {31'd0, changed[2]}, 32'd0);

        // Random traffic with occasional reset
        for (int i = 0; i < 40; i++)
            step(($urandom_range(0, 9) == 0), 4'($urandom), 4'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
